// File: rtl/dump_sched.sv
// Flush scheduler for the DSEC datapath: drains a partial compression word on idle or forced flush.
// Define DUMP_SCHED_WATCHDOG_EN to build the scon_done watchdog and timeout_err.
module dump_sched #(
    parameter int IDLE_TIMEOUT = 16,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       valid_to_comp,
    input  logic [6:0] valid_bits,
    input  logic       force_flush,
    input  logic       scon_done,
    input  logic       out_valid,
    input  logic       out_rcvd,
    input  logic       err_clr,
    output logic       dump_comp,
    output logic       flush_busy,
    output logic       flush_done,
    output logic       proto_err,
    output logic       timeout_err
);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, DUMP, WAIT_SCON, WAIT_RCV, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
    logic            dump_comp_q, flush_busy_q, flush_done_q, proto_err_q, timeout_err_q;
    logic            idle_inc, idle_fire, force_go, force_empty, wd_exp;

    always_comb begin
        idle_inc    = (state_q == IDLE) && !stall && !valid_to_comp && (valid_bits != 7'd0);
        idle_fire   = idle_inc && (idle_cnt_q == IW'(IDLE_TIMEOUT - 1));
        force_go    = (state_q == IDLE) && !stall && force_flush && (valid_bits != 7'd0);
        force_empty = (state_q == IDLE) && !stall && force_flush && (valid_bits == 7'd0);
    end

`ifdef DUMP_SCHED_WATCHDOG_EN
    localparam int WW = $clog2(RESP_TIMEOUT + 1);
    logic [WW-1:0] wd_cnt_q, wd_cnt_d;

    always_comb begin
        wd_exp   = (state_q == WAIT_SCON) && !stall && (wd_cnt_q == WW'(RESP_TIMEOUT - 1));
        wd_cnt_d = wd_cnt_q;
        if (state_q != WAIT_SCON)
            wd_cnt_d = '0;
        else if (!stall && wd_cnt_q != WW'(RESP_TIMEOUT))
            wd_cnt_d = wd_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wd_cnt_q <= '0;
        else      wd_cnt_q <= wd_cnt_d;
    end
`else
    assign wd_exp = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (!stall) begin
            case (state_q)
                IDLE:      if (idle_fire || force_go) state_d = DUMP;
                DUMP:      state_d = WAIT_SCON;
                // scon_done arriving in the expiry cycle takes priority over the watchdog
                WAIT_SCON: if (scon_done) state_d = WAIT_RCV;
                           else if (wd_exp) state_d = IDLE;
                WAIT_RCV:  if (out_valid && out_rcvd) state_d = DONE;
                DONE:      state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (!stall) begin
            if (state_q != IDLE || valid_to_comp || valid_bits == 7'd0)
                idle_cnt_d = '0;
            else if (idle_cnt_q != IW'(IDLE_TIMEOUT))
                idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            idle_cnt_q    <= '0;
            dump_comp_q   <= 1'b0;
            flush_busy_q  <= 1'b0;
            flush_done_q  <= 1'b0;
            proto_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idle_cnt_q    <= idle_cnt_d;
            dump_comp_q   <= (state_d == DUMP);
            flush_busy_q  <= (state_d != IDLE);
            flush_done_q  <= (state_d == DONE) || force_empty;
            // a new error in the clearing cycle survives the clear
            proto_err_q   <= (valid_to_comp && flush_busy_q) || (proto_err_q && !err_clr);
            timeout_err_q <= (wd_exp && !scon_done) || (timeout_err_q && !err_clr);
        end
    end

    assign dump_comp   = dump_comp_q;
    assign flush_busy  = flush_busy_q;
    assign flush_done  = flush_done_q;
    assign proto_err   = proto_err_q;
    assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_dump_sched.sv
// Directed bench for dump_sched: auto/forced flush, stall, watchdog, protocol error, async reset.
module tb_dump_sched;
    logic       clk, rst, stall, valid_to_comp, force_flush, scon_done, out_valid, out_rcvd, err_clr;
    logic [6:0] valid_bits;
    logic       dump_comp, flush_busy, flush_done, proto_err, timeout_err;
    int         n_chk = 0;
    int         n_fail = 0;

    dump_sched #(.IDLE_TIMEOUT(16), .RESP_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .stall(stall), .valid_to_comp(valid_to_comp),
        .valid_bits(valid_bits), .force_flush(force_flush), .scon_done(scon_done),
        .out_valid(out_valid), .out_rcvd(out_rcvd), .err_clr(err_clr),
        .dump_comp(dump_comp), .flush_busy(flush_busy), .flush_done(flush_done),
        .proto_err(proto_err), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; valid_to_comp = 0; valid_bits = 0; force_flush = 0;
        scon_done = 0; out_valid = 0; out_rcvd = 0; err_clr = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        #3;
        chk("reset dump_comp", dump_comp, 1'b0);
        chk("reset flush_busy", flush_busy, 1'b0);
        chk("reset flush_done", flush_done, 1'b0);
        chk("reset proto_err", proto_err, 1'b0);
        chk("reset timeout_err", timeout_err, 1'b0);
        tick(); tick();
        rst = 1;
        tick();

        // automatic flush after 16 idle cycles with 23 residual bits
        for (int c = 0; c <= 25; c++) begin
            valid_to_comp = (c == 0);
            valid_bits    = (c < 24) ? 7'd23 : 7'd0;
            scon_done     = (c == 20);
            out_valid     = (c == 22);
            out_rcvd      = (c == 22);
            chk($sformatf("auto dump_comp c=%0d", c), dump_comp, c == 17);
            chk($sformatf("auto flush_done c=%0d", c), flush_done, c == 23);
            chk($sformatf("auto flush_busy c=%0d", c), flush_busy, c >= 17 && c <= 23);
            tick();
        end
        idle_inputs();

        // forced flush with nothing to drain
        for (int c = 0; c <= 2; c++) begin
            force_flush = (c == 0);
            chk($sformatf("empty flush_done c=%0d", c), flush_done, c == 1);
            chk($sformatf("empty dump_comp c=%0d", c), dump_comp, 1'b0);
            chk($sformatf("empty flush_busy c=%0d", c), flush_busy, 1'b0);
            tick();
        end
        idle_inputs();

        // forced flush with 5 bits, ignored re-force, protocol error and clear
        for (int c = 0; c <= 6; c++) begin
            force_flush   = (c == 0) || (c == 2);
            valid_bits    = (c < 2) ? 7'd5 : 7'd0;
            scon_done     = (c == 2);
            out_valid     = (c == 3);
            out_rcvd      = (c == 3);
            valid_to_comp = (c == 3) || (c == 4);
            err_clr       = (c == 4) || (c == 5);
            chk($sformatf("force dump_comp c=%0d", c), dump_comp, c == 1);
            chk($sformatf("force flush_busy c=%0d", c), flush_busy, c >= 1 && c <= 4);
            chk($sformatf("force flush_done c=%0d", c), flush_done, c == 4);
            chk($sformatf("proto_err c=%0d", c), proto_err, c == 4 || c == 5);
            tick();
        end
        idle_inputs();

        // stall for 3 cycles while in DUMP stretches dump_comp to 4 cycles
        for (int c = 0; c <= 8; c++) begin
            force_flush = (c == 0);
            valid_bits  = (c == 0) ? 7'd5 : 7'd0;
            stall       = (c >= 1 && c <= 3);
            scon_done   = (c == 5);
            out_valid   = (c == 6);
            out_rcvd    = (c == 6);
            chk($sformatf("stall dump_comp c=%0d", c), dump_comp, c >= 1 && c <= 4);
            chk($sformatf("stall flush_done c=%0d", c), flush_done, c == 7);
            chk($sformatf("stall flush_busy c=%0d", c), flush_busy, c >= 1 && c <= 7);
            tick();
        end
        idle_inputs();

        // stall in IDLE delays the automatic flush by the stall length
        for (int c = 0; c <= 24; c++) begin
            valid_to_comp = (c == 0);
            valid_bits    = (c <= 20) ? 7'd23 : 7'd0;
            stall         = (c >= 5 && c <= 7);
            scon_done     = (c == 21);
            out_valid     = (c == 22);
            out_rcvd      = (c == 22);
            chk($sformatf("idlestall dump_comp c=%0d", c), dump_comp, c == 20);
            chk($sformatf("idlestall flush_done c=%0d", c), flush_done, c == 23);
            chk($sformatf("idlestall flush_busy c=%0d", c), flush_busy, c >= 20 && c <= 23);
            tick();
        end
        idle_inputs();

`ifdef DUMP_SCHED_WATCHDOG_EN
        // scon_done never comes: watchdog aborts at d+1+RESP_TIMEOUT
        for (int c = 0; c <= 68; c++) begin
            force_flush = (c == 0);
            valid_bits  = (c == 0) ? 7'd5 : 7'd0;
            err_clr     = (c == 66);
            chk($sformatf("wd flush_busy c=%0d", c), flush_busy, c >= 1 && c <= 65);
            chk($sformatf("wd timeout_err c=%0d", c), timeout_err, c == 66);
            tick();
        end
        idle_inputs();
        // scon_done in the expiry cycle wins over the watchdog
        for (int c = 0; c <= 68; c++) begin
            force_flush = (c == 0);
            valid_bits  = (c == 0) ? 7'd5 : 7'd0;
            scon_done   = (c == 65);
            out_valid   = (c == 66);
            out_rcvd    = (c == 66);
            chk($sformatf("wdrace flush_busy c=%0d", c), flush_busy, c >= 1 && c <= 67);
            chk($sformatf("wdrace timeout_err c=%0d", c), timeout_err, 1'b0);
            chk($sformatf("wdrace flush_done c=%0d", c), flush_done, c == 67);
            tick();
        end
`else
        // without the watchdog WAIT_SCON waits indefinitely
        for (int c = 0; c <= 145; c++) begin
            force_flush = (c == 0);
            valid_bits  = (c == 0) ? 7'd5 : 7'd0;
            scon_done   = (c == 140);
            out_valid   = (c == 141);
            out_rcvd    = (c == 141);
            chk($sformatf("nowd flush_busy c=%0d", c), flush_busy, c >= 1 && c <= 142);
            chk($sformatf("nowd timeout_err c=%0d", c), timeout_err, 1'b0);
            chk($sformatf("nowd flush_done c=%0d", c), flush_done, c == 142);
            tick();
        end
`endif
        idle_inputs();

        // asynchronous reset while in WAIT_SCON
        for (int c = 0; c <= 2; c++) begin
            force_flush = (c == 0);
            valid_bits  = (c == 0) ? 7'd5 : 7'd0;
            tick();
        end
        idle_inputs();
        chk("pre-reset flush_busy", flush_busy, 1'b1);
        scon_done = 1; out_valid = 1; out_rcvd = 1;
        rst = 0;
        #2;
        chk("async reset flush_busy", flush_busy, 1'b0);
        chk("async reset dump_comp", dump_comp, 1'b0);
        chk("async reset flush_done", flush_done, 1'b0);
        chk("async reset proto_err", proto_err, 1'b0);
        chk("async reset timeout_err", timeout_err, 1'b0);
        tick();
        rst = 1;
        idle_inputs();
        for (int c = 0; c <= 3; c++) begin
            tick();
            chk($sformatf("post-reset flush_done c=%0d", c), flush_done, 1'b0);
            chk($sformatf("post-reset flush_busy c=%0d", c), flush_busy, 1'b0);
            chk($sformatf("post-reset dump_comp c=%0d", c), dump_comp, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dump_sched.md
# dump_sched

Flush scheduler for the data stream compression/encryption (DSEC) datapath. It watches compression-module occupancy (`valid_bits`) and input activity, and raises `dump_comp` to drain a partial word when the stream idles or when software forces a flush. It then tracks the drained word through shift-concatenation (`scon_done`) and the output handshake (`out_valid`/`out_rcvd`), and reports completion. It sits beside the top-level control block and owns the `dump_comp` signal.

## Interface
Parameters:
- `IDLE_TIMEOUT`, 16: consecutive idle cycles with residual bits before an automatic flush (legal 2..255).
- `RESP_TIMEOUT`, 64: watchdog limit, in cycles, for `scon_done` after `dump_comp` (legal 2..1023).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `stall`  in  1  global hold from control; freezes state and counters.
- `valid_to_comp`  in  1  valid input presented to compression this cycle.
- `valid_bits`  in  7  residual bit count held in compression (0..64).
- `force_flush`  in  1  single-cycle flush request.
- `scon_done`  in  1  shift-concat word complete.
- `out_valid`  in  1  DSEC output valid.
- `out_rcvd`  in  1  receiver accepted the output.
- `err_clr`  in  1  clears sticky errors.
- `dump_comp`  out  1  drain request to compression.
- `flush_busy`  out  1  flush in progress; the top level deasserts `rdy` while this is high.
- `flush_done`  out  1  one-cycle completion pulse.
- `proto_err`  out  1  sticky: `valid_to_comp` arrived while `flush_busy` was high.
- `timeout_err`  out  1  sticky: watchdog expired.

## Operation
- States: IDLE, DUMP, WAIT_SCON, WAIT_RCV, DONE. Reset state is IDLE.
- All outputs are registered. All outputs are 0 while reset is asserted.
- `idle_cnt` clears when `valid_to_comp`=1 or `valid_bits`=0. Otherwise it increments while in IDLE and not stalled.
- IDLE -> DUMP when either:
  - `idle_cnt`==`IDLE_TIMEOUT`-1 and the increment condition holds, or
  - `force_flush`=1 and `valid_bits`!=0.
- IDLE with `force_flush`=1 and `valid_bits`=0: no transition; `flush_done` pulses on the next cycle.
- DUMP: `dump_comp`=1. Next state is WAIT_SCON.
- WAIT_SCON: `wd_cnt` starts at 0 on entry and increments each unstalled cycle.
  - `scon_done`=1 -> WAIT_RCV.
  - `wd_cnt`==`RESP_TIMEOUT`-1 without `scon_done` -> IDLE, and `timeout_err` is set.
  - `scon_done` in the expiry cycle wins: go to WAIT_RCV, no error.
- WAIT_RCV: `out_valid`=1 and `out_rcvd`=1 in the same cycle -> DONE.
- DONE: `flush_done`=1. Next state is IDLE; `idle_cnt` is cleared.
- `flush_busy` = (state != IDLE).
- `proto_err` is set when `valid_to_comp`=1 and `flush_busy`=1.
- `err_clr` clears both sticky errors. A set in the same cycle as `err_clr` wins.
- `force_flush` outside IDLE is ignored.
- `stall`=1:
  - State, `idle_cnt` and `wd_cnt` hold.
  - `dump_comp` and `flush_done` remain asserted if their state is current, so each pulse extends across the stall.
  - Error capture continues.
- Counter widths: `$clog2(limit+1)`. Counters never wrap.
- Reset mid-flush aborts immediately to IDLE with all counters 0. No `flush_done` is issued.

## Timing
- Automatic flush: `valid_to_comp` last high in cycle 0 with `valid_bits`!=0 from then on -> `dump_comp` high in cycle `IDLE_TIMEOUT`+1 for exactly one unstalled cycle.
- Forced flush: `force_flush` in cycle n -> `dump_comp` in cycle n+1.
- `scon_done` in cycle m -> state WAIT_RCV from m+1.
- Handshake in cycle p -> `flush_done` high in cycle p+1, back in IDLE at p+2.
- Watchdog: `dump_comp` in cycle d, no `scon_done` -> `timeout_err`=1 and `flush_busy`=0 from cycle d+1+`RESP_TIMEOUT`.

## Configuration
- `DUMP_SCHED_WATCHDOG_EN`:
  - Defined: watchdog counter and `timeout_err` are implemented as above.
  - Undefined: no `wd_cnt`; WAIT_SCON waits indefinitely for `scon_done`; `timeout_err` is tied to 0; `RESP_TIMEOUT` is unused.

## Test plan
- Reset while in WAIT_SCON (`rst`=0 for 1 cycle, asynchronous) -> all outputs 0 immediately; state IDLE; no `flush_done`.
- `valid_bits`=23, `valid_to_comp` pulsed in cycle 0, defaults -> `dump_comp` high only in cycle 17; `scon_done` at cycle 20; `out_valid`+`out_rcvd` at 22 -> `flush_done` at 23 only; `flush_busy` high cycles 17-23.
- `force_flush` with `valid_bits`=0 -> no `dump_comp`; `flush_done` one cycle later. Repeat with `valid_bits`=5 -> `dump_comp` next cycle.
- Watchdog enabled, `RESP_TIMEOUT`=64, `scon_done` never arrives -> `timeout_err`=1 at cycle d+65; `err_clr` -> 0. Variant: `scon_done` in the expiry cycle -> WAIT_RCV, no error. Macro undefined -> waits indefinitely, `timeout_err`=0.
- `valid_to_comp`=1 while in WAIT_RCV -> `proto_err`=1 and stays 1; `err_clr` together with a new violation -> stays 1.
- `stall`=1 for 3 cycles during DUMP -> `dump_comp` held for 4 cycles; `idle_cnt` frozen during a stall in IDLE, so the flush is delayed by exactly the stall length.
